// File: rtl/ac_checker_if.sv
// Observation bus of the accumulator checker: the stimulus the DUT sees,
// the DUT's sum, and the checker's verdict and status outputs.
interface ac_checker_if;
  logic        en;
  logic        dut_clr;
  logic [7:0]  in;
  logic [15:0] sum;
  logic [15:0] exp_sum;
  logic        mismatch;
  logic [7:0]  err_cnt;
  logic [15:0] chk_cnt;
  logic [15:0] first_got;
  logic [15:0] first_exp;
  logic [1:0]  state;

  modport master (
    output en, dut_clr, in, sum,
    input  exp_sum, mismatch, err_cnt, chk_cnt, first_got, first_exp, state
  );

  modport slave (
    input  en, dut_clr, in, sum,
    output exp_sum, mismatch, err_cnt, chk_cnt, first_got, first_exp, state
  );
endinterface

// File: rtl/ac_checker.sv
// Online checker for a 16-bit accumulator DUT with LAT cycles of latency:
// keeps a reference sum, aligns it to the DUT output and counts mismatches.
module ac_checker #(
  parameter int unsigned LAT         = 1,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  ac_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam logic [1:0] WARM_LAST = 2'(LAT - 1);

  state_t      r_state;
  logic [1:0]  r_wcnt;
  // r_pipe[0] is the model accumulator; r_pipe[LAT-1] is the aligned expectation.
  logic [15:0] r_pipe [LAT];
  logic        r_mismatch;
  logic [7:0]  r_err_cnt;
  logic [15:0] r_chk_cnt;
  logic [15:0] r_first_got;
  logic [15:0] r_first_exp;

  logic [15:0] w_exp_sum;
  logic        w_clr_req;
  logic        w_cmp;
  logic        w_bad;

  assign w_exp_sum = r_pipe[LAT-1];
  assign w_clr_req = bus.dut_clr && (r_state == WARM || r_state == CHECK);
  assign w_cmp     = (r_state == CHECK) && bus.en;
  assign w_bad     = w_cmp && (bus.sum != w_exp_sum);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wcnt      <= '0;
      for (int unsigned i = 0; i < LAT; i++) r_pipe[i] <= '0;
      r_mismatch  <= 1'b0;
      r_err_cnt   <= '0;
      r_chk_cnt   <= '0;
      r_first_got <= '0;
      r_first_exp <= '0;
    end else begin
      r_mismatch <= 1'b0;

      if (r_state == IDLE) begin
        if (bus.en) begin
          for (int unsigned i = 0; i < LAT; i++) r_pipe[i] <= '0;
        end
      end else if (w_clr_req) begin
        for (int unsigned i = 0; i < LAT; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= r_pipe[0] + {8'h00, bus.in};
        for (int unsigned i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end

      if (w_cmp) begin
        if (r_chk_cnt != '1) r_chk_cnt <= r_chk_cnt + 16'd1;
        if (w_bad) begin
          r_mismatch <= 1'b1;
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 8'd1;
          if (r_err_cnt == '0) begin
            r_first_got <= bus.sum;
            r_first_exp <= w_exp_sum;
          end
        end
      end

      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_state     <= WARM;
            r_wcnt      <= WARM_LAST;
            r_err_cnt   <= '0;
            r_chk_cnt   <= '0;
            r_first_got <= '0;
            r_first_exp <= '0;
          end
        end
        WARM: begin
          if (!bus.en)            r_state <= IDLE;
          else if (bus.dut_clr)   r_wcnt  <= WARM_LAST;
          else if (r_wcnt == '0)  r_state <= CHECK;
          else                    r_wcnt  <= r_wcnt - 2'd1;
        end
        CHECK: begin
          if (!bus.en) begin
            r_state <= IDLE;
          end else if (w_bad && STOP_ON_ERR) begin
            r_state <= FAIL;
          end else if (bus.dut_clr) begin
            r_state <= WARM;
            r_wcnt  <= WARM_LAST;
          end
        end
        FAIL: begin
          if (!bus.en) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.exp_sum   = w_exp_sum;
  assign bus.mismatch  = r_mismatch;
  assign bus.err_cnt   = r_err_cnt;
  assign bus.chk_cnt   = r_chk_cnt;
  assign bus.first_got = r_first_got;
  assign bus.first_exp = r_first_exp;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_ac_checker.sv
// Scoreboard bench: two checkers (LAT=1 free-running, LAT=3 stop-on-error)
// watch a behavioural accumulator DUT into which sum errors are injected.
module tb_ac_checker;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en      = 1'b0;
  logic        dut_clr = 1'b0;
  logic [7:0]  din     = '0;
  logic [15:0] msk_a   = '0;
  logic [15:0] msk_b   = '0;

  // Stand-in DUT: accumulator whose output trails its input by LAT cycles.
  logic [15:0] acc, d1, d2;
  always @(posedge clk) begin
    if (!rst) begin
      acc <= '0; d1 <= '0; d2 <= '0;
    end else begin
      acc <= dut_clr ? 16'h0000 : acc + {8'h00, din};
      d1  <= acc;
      d2  <= d1;
    end
  end

  ac_checker_if bus_a ();
  ac_checker_if bus_b ();

  assign bus_a.en = en;  assign bus_a.dut_clr = dut_clr;  assign bus_a.in = din;
  assign bus_b.en = en;  assign bus_b.dut_clr = dut_clr;  assign bus_b.in = din;
  assign bus_a.sum = acc ^ msk_a;
  assign bus_b.sum = d2  ^ msk_b;

  ac_checker #(.LAT(LAT_A), .STOP_ON_ERR(1'b0)) u_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  ac_checker #(.LAT(LAT_B), .STOP_ON_ERR(1'b1)) u_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  typedef struct packed {
    logic [1:0]  st;
    logic [15:0] ex;
    logic        mis;
    logic [7:0]  err;
    logic [15:0] chk;
    logic [15:0] fg;
    logic [15:0] fe;
  } exp_t;

  exp_t q_a [$];
  exp_t q_b [$];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: prefix sums of every byte accepted since the last clear;
  // the expectation is the prefix that excludes the newest LAT-1 bytes.
  int unsigned md_pre [2][8192];
  int unsigned md_n   [2];
  int          md_ph  [2];
  int          md_wl  [2];
  int unsigned md_err [2];
  int unsigned md_chk [2];
  int unsigned md_fg  [2];
  int unsigned md_fe  [2];
  bit          md_mis [2];

  function automatic int unsigned lat_of(int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic bit stop_of(int k);
    return (k == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic int unsigned md_exp(int k);
    int unsigned lag = lat_of(k) - 1;
    return (md_n[k] >= lag) ? md_pre[k][md_n[k] - lag] : 0;
  endfunction

  task automatic md_step(input int k, input logic r, input logic e, input logic c,
                         input logic [7:0] d, input logic [15:0] s);
    int unsigned ex;
    bit cmp, bad, wc;
    if (!r) begin
      md_ph[k] = 0; md_n[k] = 0; md_pre[k][0] = 0;
      md_err[k] = 0; md_chk[k] = 0; md_fg[k] = 0; md_fe[k] = 0; md_mis[k] = 0;
      return;
    end
    ex  = md_exp(k);
    cmp = (md_ph[k] == 2) && e;
    bad = cmp && (s != 16'(ex));
    md_mis[k] = 0;
    if (cmp) begin
      if (md_chk[k] < 65535) md_chk[k]++;
      if (bad) begin
        md_mis[k] = 1;
        if (md_err[k] == 0) begin md_fg[k] = s; md_fe[k] = ex; end
        if (md_err[k] < 255) md_err[k]++;
      end
    end
    wc = c && (md_ph[k] == 1 || md_ph[k] == 2);
    if (md_ph[k] == 0) begin
      if (e) md_n[k] = 0;
    end else if (wc) begin
      md_n[k] = 0;
    end else if (md_n[k] < 8191) begin
      md_pre[k][md_n[k] + 1] = (md_pre[k][md_n[k]] + d) % 65536;
      md_n[k]++;
    end
    case (md_ph[k])
      0: if (e) begin
           md_ph[k] = 1; md_wl[k] = lat_of(k);
           md_err[k] = 0; md_chk[k] = 0; md_fg[k] = 0; md_fe[k] = 0;
         end
      1: if (!e) md_ph[k] = 0;
         else if (c) md_wl[k] = lat_of(k);
         else begin md_wl[k]--; if (md_wl[k] == 0) md_ph[k] = 2; end
      2: if (!e) md_ph[k] = 0;
         else if (bad && stop_of(k)) md_ph[k] = 3;
         else if (c) begin md_ph[k] = 1; md_wl[k] = lat_of(k); end
      default: if (!e) md_ph[k] = 0;
    endcase
  endtask

  function automatic exp_t md_out(int k);
    exp_t o;
    o.st  = 2'(md_ph[k]);
    o.ex  = 16'(md_exp(k));
    o.mis = md_mis[k];
    o.err = 8'(md_err[k]);
    o.chk = 16'(md_chk[k]);
    o.fg  = 16'(md_fg[k]);
    o.fe  = 16'(md_fe[k]);
    return o;
  endfunction

  // mode: 0 = correct sum, 1 = sum with bit 15 flipped, 2 = sum forced to 0x1234
  task automatic tick(input logic r, input logic e, input logic c, input logic [7:0] d,
                      input int ma, input int mb);
    @(posedge clk);
    #2;
    rst = r; en = e; dut_clr = c; din = d;
    msk_a = (ma == 1) ? 16'h8000 : (ma == 2) ? (acc ^ 16'h1234) : 16'h0000;
    msk_b = (mb == 1) ? 16'h8000 : (mb == 2) ? (d2  ^ 16'h1234) : 16'h0000;
    #1;
    md_step(0, r, e, c, d, acc ^ msk_a);
    md_step(1, r, e, c, d, d2 ^ msk_b);
    q_a.push_back(md_out(0));
    q_b.push_back(md_out(1));
  endtask

  task automatic cmp_f(input string nm, input int k, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s[%0d] t=%0t got %h want %h", nm, k, $time, act, req);
    end
  endtask

  task automatic cmp_all(input int k, input exp_t a, input exp_t w);
    cmp_f("state",     k, 16'(a.st),  16'(w.st));
    cmp_f("exp_sum",   k, a.ex,       w.ex);
    cmp_f("mismatch",  k, 16'(a.mis), 16'(w.mis));
    cmp_f("err_cnt",   k, 16'(a.err), 16'(w.err));
    cmp_f("chk_cnt",   k, a.chk,      w.chk);
    cmp_f("first_got", k, a.fg,       w.fg);
    cmp_f("first_exp", k, a.fe,       w.fe);
  endtask

  initial begin : monitor
    exp_t wa, wb, aa, ab;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0 && q_b.size() > 0) begin
        wa = q_a.pop_front();
        wb = q_b.pop_front();
        aa = {bus_a.state, bus_a.exp_sum, bus_a.mismatch, bus_a.err_cnt,
              bus_a.chk_cnt, bus_a.first_got, bus_a.first_exp};
        ab = {bus_b.state, bus_b.exp_sum, bus_b.mismatch, bus_b.err_cnt,
              bus_b.chk_cnt, bus_b.first_got, bus_b.first_exp};
        cmp_all(0, aa, wa);
        cmp_all(1, ab, wb);
      end
    end
  end

  initial begin : driver
    bit   forced;
    logic pe;
    logic e, c;
    int   ma, mb;

    repeat (3) tick(0, 0, 0, 8'h00, 0, 0);

    // Steady accumulation of 0x05
    tick(1, 1, 1, 8'h05, 0, 0);
    repeat (8) tick(1, 1, 0, 8'h05, 0, 0);

    // Forced 0x1234 while exp_sum is 0x0010, then a later second error
    tick(1, 0, 0, 8'h00, 0, 0);
    tick(1, 1, 1, 8'h02, 0, 0);
    forced = 0;
    for (int i = 0; i < 30; i++) begin
      ma = 0;
      if (!forced && md_ph[0] == 2 && md_exp(0) == 16) begin ma = 2; forced = 1; end
      else if (i == 25) ma = 1;
      mb = (i == 20) ? 1 : 0;
      tick(1, 1, 0, 8'h02, ma, mb);
    end

    // Stop-on-error instance sits in FAIL; leave and re-enter
    repeat (4) tick(1, 1, 0, 8'h03, 0, 0);
    tick(1, 0, 0, 8'h00, 0, 0);
    tick(1, 1, 1, 8'h04, 0, 0);
    repeat (6) tick(1, 1, 0, 8'h04, 0, 0);

    // Clear pulse in CHECK restarts warm-up
    repeat (10) tick(1, 1, 0, 8'($urandom_range(0, 255)), 0, 0);
    tick(1, 1, 1, 8'($urandom_range(0, 255)), 0, 0);
    repeat (10) tick(1, 1, 0, 8'($urandom_range(0, 255)), 0, 0);

    // 0xFF accumulated past the 16-bit wrap
    tick(1, 0, 0, 8'h00, 0, 0);
    tick(1, 1, 1, 8'hFF, 0, 0);
    repeat (262) tick(1, 1, 0, 8'hFF, 0, 0);

    // Randomised traffic: clears, enable drops, injected errors
    pe = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      e  = pe ? ($urandom_range(0, 49) != 0) : ($urandom_range(0, 3) == 0);
      c  = (e && !pe) ? 1'b1 : ($urandom_range(0, 29) == 0);
      ma = ($urandom_range(0, 24) == 0) ? int'($urandom_range(1, 2)) : 0;
      mb = ($urandom_range(0, 39) == 0) ? 1 : 0;
      tick(1, e, c, 8'($urandom_range(0, 255)), ma, mb);
      pe = e;
    end

    // Error count saturation, then reset in the middle of checking
    tick(1, 0, 0, 8'h00, 0, 0);
    tick(1, 1, 1, 8'h11, 0, 0);
    repeat (300) tick(1, 1, 0, 8'($urandom_range(0, 255)), 1, 1);
    repeat (5) tick(1, 1, 0, 8'($urandom_range(0, 255)), 0, 0);
    repeat (2) tick(0, 1, 0, 8'h22, 1, 1);
    tick(1, 0, 0, 8'h00, 0, 0);
    tick(1, 1, 1, 8'h01, 0, 0);
    repeat (6) tick(1, 1, 0, 8'h01, 0, 0);

    @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ac_checker.md
AC_CHECKER -- requirements
Module: ac_checker

Interface
REQ-001 Parameter LAT, default 1, DUT input-to-sum latency in cycles; legal range 1..4.
REQ-002 Parameter STOP_ON_ERR, default 0; 1 = halt comparison at first mismatch.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  enable checking; level-sensitive.
REQ-006 dut_clr  input  1  observed accumulator clear, active-high, same cycle as DUT sees it.
REQ-007 in  input  8  observed accumulator input byte.
REQ-008 sum  input  16  observed accumulator output.
REQ-009 exp_sum  output  16  expected sum aligned to the cycle in which sum is compared.
REQ-010 mismatch  output  1  one-cycle pulse, registered, for a failed compare.
REQ-011 err_cnt  output  8  saturating mismatch count.
REQ-012 chk_cnt  output  16  saturating count of compares performed.
REQ-013 first_got / first_exp  output  16 each  sum and exp_sum of the first mismatch since leaving IDLE.
REQ-014 state  output  2  FSM state: IDLE=0, WARM=1, CHECK=2, FAIL=3.

Function
REQ-015 Model register m SHALL update as m <= m + zero-extended in, modulo 2^16, every cycle state != IDLE and dut_clr=0.
REQ-016 exp_sum SHALL equal m delayed by LAT-1 additional register stages; with LAT=1, exp_sum = m.
REQ-017 The delay stages SHALL shift every cycle state != IDLE.
REQ-018 IDLE -> WARM when en=1; m and the delay stages SHALL load 0 on that transition.
REQ-019 WARM SHALL last exactly LAT cycles, then go to CHECK; no compares in WARM.
REQ-020 In CHECK, each cycle SHALL compare sum to exp_sum; chk_cnt increments; on inequality mismatch pulses next cycle and err_cnt increments.
REQ-021 CHECK -> FAIL on a mismatch when STOP_ON_ERR=1; with STOP_ON_ERR=0, stay in CHECK.
REQ-022 FAIL SHALL perform no compares; counters and captures hold.
REQ-023 Any state other than IDLE -> IDLE when en=0; counters and captures SHALL hold in IDLE until the next IDLE -> WARM transition, which clears them.
REQ-024 dut_clr=1 in WARM or CHECK: m and delay stages SHALL load 0; enter or restart WARM for LAT cycles.
REQ-025 dut_clr=1 in FAIL or IDLE SHALL be ignored.
REQ-026 dut_clr and en=0 in the same cycle: en=0 wins, go to IDLE.
REQ-027 err_cnt SHALL saturate at 255 and chk_cnt at 65535; neither wraps.
REQ-028 first_got and first_exp SHALL capture only when err_cnt=0 at the failing compare.
REQ-029 Sum wrap, e.g. 0xFFFF + 0x01 = 0x0000, is legal and SHALL NOT be flagged.

Reset
REQ-030 rst=0 at a posedge SHALL force state=IDLE; m, delay stages, exp_sum, err_cnt, chk_cnt, first_got and first_exp = 0; mismatch = 0.
REQ-031 Reset mid-operation SHALL abandon any compare in that cycle with no mismatch pulse.
REQ-032 After rst returns to 1, the first transition SHALL occur no earlier than the next posedge.

Verification
REQ-033 LAT=1, en=1, in=0x05 for 4 cycles, correct DUT -> WARM 1 cycle; CHECK exp_sum 0x0005, 0x000A, ...; err_cnt=0; chk_cnt increments per CHECK cycle.
REQ-034 Correct DUT in CHECK, sum forced to 0x1234 once while exp_sum=0x0010 -> mismatch pulses 1 cycle; err_cnt=1; first_got=0x1234, first_exp=0x0010; a second error leaves the captures unchanged.
REQ-035 STOP_ON_ERR=1, injected error -> state=FAIL; chk_cnt frozen; en=0 -> IDLE; en=1 -> counters cleared, WARM.
REQ-036 Accumulate 0xFF x 257 cycles from 0 -> exp_sum wraps 0xFFFF to 0x00FE cleanly; no mismatch.
REQ-037 LAT=3, dut_clr pulse in CHECK -> WARM for 3 cycles, exp_sum=0, then compares resume against 0-based sum; err_cnt unchanged.
REQ-038 300 forced mismatches, STOP_ON_ERR=0 -> err_cnt=255 held; rst=0 mid-run -> all outputs 0, state=IDLE.
